// File: rtl/led_pattern_chaser_if.sv
// Control/status bundle for led_pattern_chaser.
// The master drives the seed and run controls; the slave returns the LED drive and the step status.
interface led_pattern_chaser_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
);
  logic [WIDTH-1:0] init_pattern;
  logic             load;
  logic             enable;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] led;
  logic             step_tick;
  logic             dir;

  modport master (
    output init_pattern, load, enable, mode, div,
    input  led, step_tick, dir
  );

  modport slave (
    input  init_pattern, load, enable, mode, div,
    output led, step_tick, dir
  );
endinterface

// File: rtl/led_pattern_chaser.sv
// Prescaled LED pattern chaser: rotate-left, rotate-right, bounce and blink modes.
// Define LED_ACTIVE_LOW_EN to invert the LED drive for common-anode boards.
module led_pattern_chaser #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  led_pattern_chaser_if.slave  bus
);
  localparam logic [DIV_W-1:0] COUNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pattern_reg, pattern_next;
  logic [DIV_W-1:0] count_reg, count_next;
  logic             dir_reg, dir_next;
  logic             tick_reg, tick_next;

  logic [WIDTH-1:0] rol, ror, shl, shr;

  // Per-bit neighbour wiring for the four shift/rotate candidates.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
    assign rol[gi] = pattern_reg[(gi + WIDTH - 1) % WIDTH];
    assign ror[gi] = pattern_reg[(gi + 1) % WIDTH];
    if (gi == 0) begin : g_lsb
      assign shl[gi] = 1'b0;
    end else begin : g_upper
      assign shl[gi] = pattern_reg[gi-1];
    end
    if (gi == WIDTH - 1) begin : g_msb
      assign shr[gi] = 1'b0;
    end else begin : g_lower
      assign shr[gi] = pattern_reg[gi+1];
    end
  end

  always_comb begin
    pattern_next = pattern_reg;
    count_next   = count_reg;
    dir_next     = dir_reg;
    tick_next    = 1'b0;
    if (bus.load) begin
      pattern_next = bus.init_pattern;
      count_next   = '0;
      dir_next     = 1'b0;
    end else if (bus.enable) begin
      // >= so that lowering div below the running count steps immediately.
      if (count_reg >= bus.div) begin
        count_next = '0;
        tick_next  = 1'b1;
        unique case (bus.mode)
          2'b00: pattern_next = rol;
          2'b01: pattern_next = ror;
          2'b10: begin
            if (!dir_reg) begin
              if (pattern_reg[WIDTH-1]) begin
                dir_next     = 1'b1;
                pattern_next = shr;
              end else begin
                pattern_next = shl;
              end
            end else begin
              if (pattern_reg[0]) begin
                dir_next     = 1'b0;
                pattern_next = shl;
              end else begin
                pattern_next = shr;
              end
            end
          end
          default: pattern_next = ~pattern_reg;
        endcase
      end else begin
        count_next = count_reg + COUNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_reg <= bus.init_pattern;
      count_reg   <= '0;
      dir_reg     <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      pattern_reg <= pattern_next;
      count_reg   <= count_next;
      dir_reg     <= dir_next;
      tick_reg    <= tick_next;
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign bus.led = ~pattern_reg;
`else
  assign bus.led = pattern_reg;
`endif
  assign bus.step_tick = tick_reg;
  assign bus.dir       = dir_reg;
endmodule

// File: doc/led_pattern_chaser.md
Name: led_pattern_chaser

Overview:
Parametrised LED pattern generator, successor to the fixed 8-bit chaser. It drives a WIDTH-bit LED bank from a loadable seed pattern. The step rate comes from a built-in prescaler. Four run-time modes: rotate-left, rotate-right, bounce and blink. It sits directly in front of the board LED pins, clocked by the system clock.

Parameters:
WIDTH, 8, number of LEDs / pattern bits (>= 2)
DIV_W, 16, width of the step-period divider input and internal prescale counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
init_pattern  input  WIDTH  seed pattern, sampled on reset and on load
load  input  1  single-cycle request to reload the seed pattern
enable  input  1  run/pause; low freezes the prescaler and the pattern
mode  input  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 blink
div  input  DIV_W  step period minus one, in clock cycles
led  output  WIDTH  LED drive (pattern register, see Optional Feature)
step_tick  output  1  one-cycle pulse, registered with each pattern advance
dir  output  1  bounce direction: 0 = toward MSB, 1 = toward LSB

Behaviour:
- Only one clock; reset is synchronous and active-high.
- Reset values: pattern <= init_pattern, prescale counter <= 0, dir <= 0, step_tick <= 0.
- Priority, highest first: reset, load, step, hold.
- load: pattern <= init_pattern, counter <= 0, dir <= 0, step_tick <= 0. A load in the same cycle as a due step cancels that step.
- Prescaler, active only when enable = 1:
  - If counter >= div, this is a step: counter <= 0, pattern advances, step_tick <= 1.
  - Otherwise counter <= counter + 1 and step_tick <= 0.
  - The >= compare makes a div reduction below the current count take effect on the next enabled cycle.
  - div = 0 steps every cycle.
  - With enable held high from a counter value of 0, the first step lands on the (div+1)-th edge.
- enable = 0: counter, pattern and dir hold; step_tick <= 0. Resuming continues from the held count.
- Step rules per mode:
  - 00: rotate left; bit WIDTH-1 wraps to bit 0.
  - 01: rotate right; bit 0 wraps to bit WIDTH-1.
  - 10, dir = 0: if pattern[WIDTH-1] = 1, set dir <= 1 and shift right logically (zero fill). Otherwise shift left logically.
  - 10, dir = 1: if pattern[0] = 1, set dir <= 0 and shift left. Otherwise shift right.
  - 10, all-zero pattern: stays all-zero and dir holds.
  - 11: pattern <= ~pattern.
- dir changes only in mode 10. It is retained across mode changes and cleared only by reset or load.
- A mode change mid-run takes effect at the next step. There is no reload.
- Zero-pattern rotation is legal and stays zero.
- Reset mid-run: next edge shows init_pattern; first step at the (div+1)-th enabled cycle after reset deasserts.

Optional Feature:
Macro LED_ACTIVE_LOW_EN.
- Defined: led = ~pattern, for common-anode boards. The internal pattern, step_tick and dir are unaffected. During reset, led shows ~init_pattern.
- Undefined: led = pattern.
- Either way, led is driven directly from the register, with no combinational path from inputs.

Test Plan:
1. WIDTH=8, reset high 2 cycles, init_pattern=8'h03, mode=00, div=0, enable=1 -> led=03 during reset, then 06,0C,18,30,60,C0,81,03 on consecutive edges; step_tick high every cycle.
2. init_pattern=8'h01, load pulse, mode=01, div=2 -> led 01 for 3 cycles, then 80,40,20 each held 3 cycles; step_tick one-cycle pulse every 3rd cycle.
3. init_pattern=8'h01, mode=10, div=0 -> 02,04,08,10,20,40,80 with dir=0, then 40 with dir=1, down to 01, then 02 with dir=0.
4. mode=11, init_pattern=8'hA5, div=1 -> led alternates A5/5A every 2 cycles. Assert load on a step cycle -> led=A5, counter=0, no step_tick that cycle.
5. mode=00, div=4, drop enable for 10 cycles two cycles after a step -> led, counter and step_tick frozen/low. After re-enable, the next step comes 3 cycles later.
6. Mid-run, change div from 10 to 1 while counter=6 -> step on the next edge, then every 2 cycles. Assert reset mid-run -> led=init_pattern on the next edge and dir=0. Repeat case 1 with LED_ACTIVE_LOW_EN -> led shows FC,F9,F3,...
